// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with enable, output polarity select and
// a prescaled round-robin auto-scan mode for strobe driving.
module decoder_n_scan #(
    parameter int N          = 2,
    parameter int ACTIVE_LOW = 0,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N-1:0]         w,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [2**N-1:0]      y,
    output logic [N-1:0]         idx,
    output logic                 tick
);

    localparam int W = 2**N;
    localparam logic [W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cnt_next;
    logic [N-1:0]         idx_next;
    logic                 tick_next;
    logic [W-1:0]         onehot;
    logic [W-1:0]         y_next;

    always_comb begin
        cnt_next  = cnt;
        idx_next  = idx;
        tick_next = 1'b0;
        if (en) begin
            if (!mode) begin
                idx_next = w;
                cnt_next = '0;
            end else if (cnt >= div) begin
                // >= so a div lowered below the running count wraps at once
                cnt_next  = '0;
                idx_next  = idx + 1'b1;
                tick_next = 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // y decodes the index being loaded on this edge, so it never lags idx
    always_comb begin
        onehot = {{(W-1){1'b0}}, 1'b1} << idx_next;
        y_next = INACTIVE;
        if (en) begin
            y_next = (ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y    <= INACTIVE;
            idx  <= '0;
            tick <= 1'b0;
            cnt  <= '0;
        end else begin
            y    <= y_next;
            idx  <= idx_next;
            tick <= tick_next;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_decoder_n_scan.sv
// Scoreboard bench for decoder_n_scan: one active-high and one active-low
// instance share stimulus; expected outputs are queued per clock edge.
module tb_decoder_n_scan;

    typedef struct {
        logic [3:0] y;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  w = '0;
    logic [15:0] div = '0;
    logic [3:0]  y_h, y_l;
    logic [1:0]  idx_h, idx_l;
    logic        tick_h, tick_l;

    exp_t exq[$];
    int   checks = 0;
    int   failures = 0;
    int   step = 0;

    always #5 clk = ~clk;

    decoder_n_scan #(.N(2), .ACTIVE_LOW(0), .DIV_WIDTH(16)) dut_h (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w), .div(div),
        .y(y_h), .idx(idx_h), .tick(tick_h)
    );

    decoder_n_scan #(.N(2), .ACTIVE_LOW(1), .DIV_WIDTH(16)) dut_l (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w), .div(div),
        .y(y_l), .idx(idx_l), .tick(tick_l)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", nm, step, act, ex);
        end
    endtask

    // Inputs change on the falling edge; the next rising edge consumes them.
    task automatic drv(input logic r, input logic e, input logic m, input logic [1:0] ww,
                       input logic [15:0] dv, input logic [3:0] ey, input logic [1:0] ei,
                       input logic et);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        mode = m;
        w    = ww;
        div  = dv;
        x.y    = ey;
        x.idx  = ei;
        x.tick = et;
        exq.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exq.size() > 0) begin
                x = exq.pop_front();
                step++;
                check("y_active_high", {28'd0, y_h}, {28'd0, x.y});
                check("y_active_low", {28'd0, y_l}, {28'd0, ~x.y});
                check("idx_high", {30'd0, idx_h}, {30'd0, x.idx});
                check("idx_low", {30'd0, idx_l}, {30'd0, x.idx});
                check("tick_high", {31'd0, tick_h}, {31'd0, x.tick});
                check("tick_low", {31'd0, tick_l}, {31'd0, x.tick});
            end
        end
    end

    initial begin : stimulus
        // reset held two cycles
        drv(1, 0, 0, 2'd0, 16'd0, 4'b0000, 2'd0, 0);
        drv(1, 1, 1, 2'd3, 16'd0, 4'b0000, 2'd0, 0);
        // manual decode, one edge of latency
        drv(0, 1, 0, 2'd0, 16'd0, 4'b0001, 2'd0, 0);
        drv(0, 1, 0, 2'd1, 16'd0, 4'b0010, 2'd1, 0);
        drv(0, 1, 0, 2'd2, 16'd0, 4'b0100, 2'd2, 0);
        drv(0, 1, 0, 2'd3, 16'd0, 4'b1000, 2'd3, 0);
        // disable: outputs inactive, idx held
        drv(0, 0, 0, 2'd1, 16'd0, 4'b0000, 2'd3, 0);
        // scan div=3 from reset; w ignored
        drv(1, 0, 0, 2'd0, 16'd0, 4'b0000, 2'd0, 0);
        for (int k = 1; k <= 16; k++)
            drv(0, 1, 1, 2'd3, 16'd3, 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4), (k % 4) == 0);
        // div=0: advance each clock, tick held high
        drv(0, 1, 1, 2'd0, 16'd0, 4'b0010, 2'd1, 1);
        drv(0, 1, 1, 2'd0, 16'd0, 4'b0100, 2'd2, 1);
        drv(0, 1, 1, 2'd0, 16'd0, 4'b1000, 2'd3, 1);
        drv(0, 1, 1, 2'd0, 16'd0, 4'b0001, 2'd0, 1);
        drv(0, 1, 1, 2'd0, 16'd0, 4'b0010, 2'd1, 1);
        for (int k = 0; k < 5; k++)
            drv(0, 0, 1, 2'd0, 16'd0, 4'b0000, 2'd1, 0);
        drv(0, 1, 1, 2'd0, 16'd0, 4'b0100, 2'd2, 1);
        // div shrink below running count
        drv(0, 1, 0, 2'd0, 16'd9, 4'b0001, 2'd0, 0);
        for (int k = 0; k < 7; k++)
            drv(0, 1, 1, 2'd2, 16'd9, 4'b0001, 2'd0, 0);
        drv(0, 1, 1, 2'd2, 16'd2, 4'b0010, 2'd1, 1);
        // scan -> manual -> scan
        drv(0, 1, 0, 2'd1, 16'd2, 4'b0010, 2'd1, 0);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b0010, 2'd1, 0);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b0010, 2'd1, 0);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b0100, 2'd2, 1);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b0100, 2'd2, 0);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b0100, 2'd2, 0);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b1000, 2'd3, 1);
        // reset mid-scan at idx=3, then restart from 0
        drv(1, 1, 1, 2'd0, 16'd2, 4'b0000, 2'd0, 0);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b0001, 2'd0, 0);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b0001, 2'd0, 0);
        drv(0, 1, 1, 2'd0, 16'd2, 4'b0010, 2'd1, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (exq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 entries left", exq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_n_scan.md
Name: decoder_n_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; next generation of the lab's 2-to-4 decoder.
- Adds an enable, an output polarity option and an auto-scan mode.
- In scan mode an internal prescaler and index counter step the active output round-robin, for driving digit/row strobes on the FPGA board.
- In manual mode it decodes the external select like the combinational decoder, with one cycle of latency.

Parameters:
- N, 2, select width; output width is 2**N.
- ACTIVE_LOW, 0, 1 inverts every bit of y (selected line 0, others 1).
- DIV_WIDTH, 16, width of the prescaler and the div port.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = outputs driven; 0 = all outputs inactive, counters frozen.
- mode  in  1  0 = manual decode of w; 1 = auto-scan.
- w  in  N  manual select.
- div  in  DIV_WIDTH  scan period minus one; index advances every div+1 enabled cycles.
- y  out  2**N  registered one-hot decode (polarity per ACTIVE_LOW).
- idx  out  N  index currently decoded onto y.
- tick  out  1  one-cycle pulse, asserted in the cycle idx/y show a newly advanced scan index.

Behaviour:
- Reset values (rst=1 at an edge, overrides all other inputs):
  - y = all inactive (0 when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1).
  - idx = 0, tick = 0, internal prescaler cnt = 0.
- Registered output:
  - y always equals onehot(idx) when en=1, polarity applied.
  - y and idx update on the same edge; never decode from a stale idx.
- en=0:
  - Next edge: y goes all inactive and tick goes 0.
  - idx and cnt hold.
  - On re-enable, y shows onehot(idx) on the first enabled edge.
- Manual mode (mode=0, en=1):
  - Each edge: idx <= w, y <= onehot(w), cnt <= 0, tick <= 0.
  - Latency is 1 clock from w to y.
- Scan mode (mode=1, en=1):
  - If cnt >= div: cnt <= 0, idx <= idx+1 mod 2**N, tick <= 1.
  - Otherwise: cnt <= cnt+1, tick <= 0.
  - The ">=" compare means that lowering div mid-count below cnt wraps on the next edge; it never runs through the full 2^DIV_WIDTH.
  - div=0: idx advances every clock and tick is held high.
  - Wrap: idx = 2**N-1 advances to 0, with no gap cycle.
- Mode changes:
  - Manual to scan: scanning starts from the current idx; cnt starts at 0, so the first advance comes div+1 cycles after the switch edge.
  - Scan to manual: next edge loads w; cnt is cleared; tick = 0.
- w is ignored in scan mode. div is sampled every cycle, with no shadow register.
- Reset mid-scan: next edge forces reset values regardless of en/mode; scanning resumes from idx 0 after rst drops.
- Width rule: idx arithmetic is N bits unsigned, modulo 2**N. cnt is DIV_WIDTH bits and never exceeds the value of div in use when it was last incremented.
- Inputs are synchronous to clk; no internal synchronisers.

Test Plan:
- Reset/manual (N=2, ACTIVE_LOW=0):
  - Hold rst 2 cycles -> y=0000, idx=0, tick=0.
  - Release, en=1, mode=0; drive w=0,1,2,3 for one cycle each -> y=0001,0010,0100,1000, each one edge after w changes.
- Polarity (ACTIVE_LOW=1):
  - After reset -> y=1111.
  - w=2 -> y=1011.
  - en=0 -> y=1111 next edge.
- Scan with div=3 from reset (en=1, mode=1):
  - idx steps 0->1->2->3->0 every 4 clocks.
  - tick high for exactly 1 cycle coincident with each step.
  - y=0001,0010,0100,1000,0001.
- div=0 scan:
  - idx advances every clock, tick constantly 1.
  - Then set en=0 for 5 cycles -> y=0000, idx frozen.
  - Re-enable -> resumes from the frozen idx.
- Mode switch and div shrink:
  - Scan with div=9 until cnt=7, then set div=2 -> advance on the next edge.
  - Switch to mode=0 with w=1 -> y=0010, tick=0 next edge.
  - Switch back to mode=1 -> first advance to idx=2 after div+1 cycles.
- Reset mid-scan: assert rst while idx=3 -> next edge y=0000, idx=0; after release, scan restarts from 0.
